// File: rtl/icache_fetch_responder.sv
// In-order fetch responder: buffers requests and serves them one at a time over a single-outstanding memory read port.
// Latency is 4 cycles from request to icache_ack with zero-wait memory; there is no backpressure, so a push while full is dropped and sets overflow_err.
module icache_fetch_responder (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    input  logic [5:0]  fetch_wfid,
    input  logic [31:0] fetch_addr,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rd_data,
    output logic        icache_ack,
    output logic [5:0]  icache_ack_wfid,
    output logic [31:0] icache_ack_data,
    output logic [5:0]  queue_count,
    output logic        overflow_err
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]  r_state;
    logic [5:0]  r_fifo_wfid [32];
    logic [31:0] r_fifo_addr [32];
    logic [4:0]  r_wr_ptr;
    logic [4:0]  r_rd_ptr;
    logic [5:0]  r_count;
    logic [5:0]  r_iss_wfid;
    logic [31:0] r_iss_addr;
    logic [5:0]  r_ack_wfid;
    logic [31:0] r_ack_data;
    logic        r_ovf;

    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_full = (r_count == 6'd32);
    assign w_push = fetch_valid && !w_full;
    // Only IDLE and RESP may pull the next entry; this keeps one read outstanding.
    assign w_pop  = ((r_state == S_IDLE) || (r_state == S_RESP)) && (r_count != 6'd0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_wfid[r_wr_ptr] <= fetch_wfid;
            r_fifo_addr[r_wr_ptr] <= fetch_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= 5'd0;
            r_rd_ptr   <= 5'd0;
            r_count    <= 6'd0;
            r_iss_wfid <= 6'd0;
            r_iss_addr <= 32'd0;
            r_ack_wfid <= 6'd0;
            r_ack_data <= 32'd0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 5'd1;
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + 5'd1;
                r_iss_wfid <= r_fifo_wfid[r_rd_ptr];
                r_iss_addr <= r_fifo_addr[r_rd_ptr];
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 6'd1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 6'd1;
            end
            if (fetch_valid && w_full) begin
                r_ovf <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Response fields are captured separately so they hold after the next pop.
                    if (mem_ack) begin
                        r_ack_wfid <= r_iss_wfid;
                        r_ack_data <= mem_rd_data;
                        r_state    <= S_RESP;
                    end
                end
                default: begin
                    r_state <= w_pop ? S_REQ : S_IDLE;
                end
            endcase
        end
    end

    assign mem_rd_en       = (r_state == S_REQ);
    assign mem_addr        = r_iss_addr & 32'hFFFF_FFFC;
    assign icache_ack      = (r_state == S_RESP);
    assign icache_ack_wfid = r_ack_wfid;
    assign icache_ack_data = r_ack_data;
    assign queue_count     = r_count;
    assign overflow_err    = r_ovf;
endmodule

// File: tb/tb_icache_fetch_responder.sv
// Randomized scoreboard bench for icache_fetch_responder; timing is predicted from request arrival times and memory latencies.
module tb_icache_fetch_responder;
    typedef struct {
        int          t;
        logic [5:0]  wfid;
        logic [31:0] data;
    } rsp_t;
    typedef struct {
        int          t;
        logic [31:0] addr;
    } rd_t;

    localparam int NEVER = 32'h7FFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic [5:0]  fetch_wfid;
    logic [31:0] fetch_addr;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rd_data;
    logic        icache_ack;
    logic [5:0]  icache_ack_wfid;
    logic [31:0] icache_ack_data;
    logic [5:0]  queue_count;
    logic        overflow_err;

    icache_fetch_responder dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_valid     (fetch_valid),
        .fetch_wfid      (fetch_wfid),
        .fetch_addr      (fetch_addr),
        .mem_rd_en       (mem_rd_en),
        .mem_addr        (mem_addr),
        .mem_ack         (mem_ack),
        .mem_rd_data     (mem_rd_data),
        .icache_ack      (icache_ack),
        .icache_ack_wfid (icache_ack_wfid),
        .icache_ack_data (icache_ack_data),
        .queue_count     (queue_count),
        .overflow_err    (overflow_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    initial forever @(posedge clk) cyc++;

    int          checks = 0;
    int          errors = 0;
    rsp_t        exp_rsp[$];
    rd_t         exp_rd[$];
    int          lat_q[$];
    int          push_t[$];
    int          pop_t[$];
    int          last_r;
    int          ovf_t;
    logic [5:0]  last_wfid;
    logic [31:0] last_data;
    logic        spur_en = 1'b0;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'hDEAD_AEEF;
    endfunction

    // Occupancy visible after edge t: accepted pushes so far minus pops so far.
    function automatic int count_at(input int t);
        int n = 0;
        foreach (push_t[i]) if (push_t[i] <= t) n++;
        foreach (pop_t[i]) if (pop_t[i] <= t) n--;
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        exp_rsp.delete();
        exp_rd.delete();
        lat_q.delete();
        push_t.delete();
        pop_t.delete();
        last_r    = -100;
        ovf_t     = NEVER;
        last_wfid = 6'd0;
        last_data = 32'd0;
    endtask

    // Request seen in cycle a; served one at a time, REQ right after the previous RESP or two cycles after arrival.
    task automatic model_push(input int a, input logic [5:0] w, input logic [31:0] addr, input int lat);
        int q;
        if (count_at(a) >= 32) begin
            if (ovf_t == NEVER) ovf_t = a + 1;
            return;
        end
        q      = (a + 1 <= last_r) ? last_r + 1 : a + 2;
        last_r = q + lat + 1;
        push_t.push_back(a + 1);
        pop_t.push_back(q);
        exp_rd.push_back(rd_t'{t: q, addr: addr & 32'hFFFF_FFFC});
        exp_rsp.push_back(rsp_t'{t: last_r, wfid: w, data: mdata(addr)});
        lat_q.push_back(lat);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [5:0] w, input logic [31:0] addr, input int lat);
        fetch_valid = 1'b1;
        fetch_wfid  = w;
        fetch_addr  = addr;
        model_push(cyc, w, addr, lat);
        @(negedge clk);
        fetch_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (exp_rsp.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("drain_timeout", exp_rsp.size(), 0);
        idle(3);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_icache_ack", icache_ack, 0);
        chk("rst_ack_wfid", icache_ack_wfid, 0);
        chk("rst_ack_data", icache_ack_data, 0);
        chk("rst_queue_count", queue_count, 0);
        chk("rst_overflow_err", overflow_err, 0);
    endtask

    // Memory model: acks lat cycles after the strobe, may also fire ignored acks outside WAIT.
    initial begin : mem_model
        logic        pend;
        logic        live;
        int          wcnt;
        logic [31:0] paddr;
        pend        = 1'b0;
        live        = 1'b0;
        wcnt        = 0;
        paddr       = 32'd0;
        mem_ack     = 1'b0;
        mem_rd_data = 32'd0;
        forever begin
            @(negedge clk);
            mem_ack     = 1'b0;
            mem_rd_data = $urandom;
            if (rst) live = 1'b0;
            if (pend && live) chk("mem_addr_hold", mem_addr, paddr);
            if (pend) begin
                if (wcnt <= 1) begin
                    mem_ack     = 1'b1;
                    mem_rd_data = mdata(paddr);
                    pend        = 1'b0;
                end else begin
                    wcnt--;
                end
            end
            if (mem_rd_en && !rst) begin
                pend  = 1'b1;
                live  = 1'b1;
                wcnt  = (lat_q.size() != 0) ? lat_q.pop_front() : 1;
                paddr = mem_addr;
                if ($urandom_range(0, 1) == 1) mem_ack = 1'b1;
            end else if (!pend && !mem_ack && spur_en && $urandom_range(0, 5) == 0) begin
                mem_ack = 1'b1;
            end
        end
    end

    initial begin : monitor
        rsp_t e;
        rd_t  d;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("queue_count", queue_count, count_at(cyc));
                chk("overflow_err", overflow_err, cyc >= ovf_t);
                if (icache_ack || (exp_rsp.size() != 0 && exp_rsp[0].t == cyc)) begin
                    if (exp_rsp.size() == 0) begin
                        chk("unexpected_icache_ack", icache_ack, 0);
                    end else begin
                        e = exp_rsp.pop_front();
                        chk("ack_cycle", cyc, e.t);
                        chk("ack_present", icache_ack, 1);
                        chk("ack_wfid", icache_ack_wfid, e.wfid);
                        chk("ack_data", icache_ack_data, e.data);
                        last_wfid = e.wfid;
                        last_data = e.data;
                    end
                end else begin
                    chk("hold_wfid", icache_ack_wfid, last_wfid);
                    chk("hold_data", icache_ack_data, last_data);
                end
                if (mem_rd_en || (exp_rd.size() != 0 && exp_rd[0].t == cyc)) begin
                    if (exp_rd.size() == 0) begin
                        chk("unexpected_mem_rd_en", mem_rd_en, 0);
                    end else begin
                        d = exp_rd.pop_front();
                        chk("rd_cycle", cyc, d.t);
                        chk("rd_present", mem_rd_en, 1);
                        chk("rd_addr", mem_addr, d.addr);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rst         = 1'b1;
        fetch_valid = 1'b0;
        fetch_wfid  = 6'd0;
        fetch_addr  = 32'd0;
        idle(3);
        chk_reset_outputs();
        rst = 1'b0;
        idle(2);

        send(6'd5, 32'h0000_1003, 1);
        drain(40);

        for (int i = 0; i < 31; i++) send(6'(i), $urandom, 3);
        drain(400);

        // Memory stalled long enough for the buffer to fill and drop one request.
        for (int i = 0; i < 34; i++) send(6'(i % 40), $urandom, (i == 0) ? 80 : 1);
        drain(600);
        chk("overflow_sticky", overflow_err, 1);

        // Third request lands in the RESP cycle of the first while one entry is queued.
        send(6'd10, 32'h0000_4000, 1);
        send(6'd11, 32'h0000_4104, 1);
        idle(2);
        send(6'd12, 32'h0000_4208, 1);
        drain(60);

        spur_en = 1'b1;
        idle(30);
        for (int i = 0; i < 150; i++) begin
            send(6'($urandom_range(0, 39)), $urandom, $urandom_range(1, 5));
            idle($urandom_range(0, 3));
        end
        drain(1500);
        spur_en = 1'b0;

        // Reset while the first of five reads waits on memory; its late ack must be ignored.
        send(6'd20, 32'h0000_8000, 12);
        for (int i = 1; i < 5; i++) send(6'(20 + i), 32'h0000_8000 + 32'(4 * i), 1);
        idle(1);
        rst = 1'b1;
        model_reset();
        #1;
        chk_reset_outputs();
        idle(2);
        rst = 1'b0;
        idle(12);
        send(6'd7, 32'h0000_2222, 2);
        drain(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
